// File: rtl/int_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// int_muldiv_unit_if
//
// Issue/result bus of the iterative multiply/divide unit.
//
// Signals
//   flush      issuer -> unit   kill any in-flight or pending operation
//   in_valid   issuer -> unit   operation offered
//   in_ready   unit -> issuer   unit is idle and can take an operation
//   in_op      issuer -> unit   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                               4 DIV, 5 DIVU, 6 REM, 7 REMU
//   in_s1      issuer -> unit   rs1 / dividend
//   in_s2      issuer -> unit   rs2 / divisor
//   in_tag     issuer -> unit   opaque issue tag
//   out_valid  unit -> consumer result available
//   out_ready  consumer -> unit result taken
//   out_result unit -> consumer result value
//   out_tag    unit -> consumer tag of the result
//
// Modports
//   master : the execute-stage issue/writeback logic
//   slave  : the multiply/divide unit
// ---------------------------------------------------------------------------
interface int_muldiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_s1;
    logic [WIDTH-1:0] in_s2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_op,
        output in_s1,
        output in_s2,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_tag
    );

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_op,
        input  in_s1,
        input  in_s2,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_tag
    );
endinterface

// File: rtl/int_muldiv_unit.sv
// ---------------------------------------------------------------------------
// int_muldiv_unit
//
// Iterative integer multiply/divide unit covering the RV M-extension op set
// at WIDTH bits. One bit is processed per clock: shift-add for multiplies,
// restoring division for DIV/REM. Signed operands are reduced to magnitudes
// when the operation is accepted, the iteration runs unsigned, and the sign
// of the result is fixed up on the last step. Divide-by-zero and signed
// overflow are resolved at accept time without iterating.
//
// At most one operation is in flight. The issue tag travels with the
// operation and is presented alongside the result.
//
// Ports
//   clk    clock
//   rst_n  asynchronous active-low reset; discards all state immediately
//   bus    int_muldiv_unit_if.slave - issue handshake, result handshake,
//          flush (see the interface file for the signal list)
//
// The WIDTH/TAG_W parameters must match those of the connected interface.
// ---------------------------------------------------------------------------
module int_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    int_muldiv_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_div_reg;    // 1: divide family, 0: multiply family
    logic             sel_alt_reg;   // mul: take high half; div: take remainder
    logic             neg_reg;       // negate the magnitude result at the end
    logic [WIDTH-1:0] opnd_reg;      // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] acc_reg;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_reg;        // multiplier then product low half / dividend then quotient
    logic [TAG_W-1:0] tag_reg;       // tag of the operation in flight
    logic [WIDTH-1:0] out_result_reg;
    logic [TAG_W-1:0] out_tag_reg;

    assign bus.in_ready   = (state_reg == ST_IDLE);
    assign bus.out_valid  = (state_reg == ST_DONE);
    assign bus.out_result = out_result_reg;
    assign bus.out_tag    = out_tag_reg;

    // -----------------------------------------------------------------------
    // Accept-time decode: operand signedness, magnitudes, result sign and
    // the divide special cases.
    // -----------------------------------------------------------------------
    logic             acc_is_div;
    logic             acc_sel_alt;
    logic             s1_signed;
    logic             s2_signed;
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] s1_mag;
    logic [WIDTH-1:0] s2_mag;
    logic             acc_neg;
    logic             div_by_zero;
    logic             div_overflow;
    logic             acc_special;
    logic [WIDTH-1:0] special_result;

    always_comb begin
        s1_signed = 1'b0;
        s2_signed = 1'b0;
        unique case (bus.in_op)
            OP_MULH:          begin s1_signed = 1'b1; s2_signed = 1'b1; end
            OP_MULHSU:        begin s1_signed = 1'b1; s2_signed = 1'b0; end
            OP_DIV, OP_REM:   begin s1_signed = 1'b1; s2_signed = 1'b1; end
            default:          begin s1_signed = 1'b0; s2_signed = 1'b0; end
        endcase

        acc_is_div  = bus.in_op[2];
        // For MULH/MULHSU/MULHU the high half is wanted; for REM/REMU the
        // remainder. In both families that is any op with a non-zero low
        // bit pair except DIV/DIVU, so decode the two families separately.
        acc_sel_alt = bus.in_op[2] ? bus.in_op[1] : (bus.in_op[1:0] != 2'b00);

        s1_neg = s1_signed & bus.in_s1[WIDTH-1];
        s2_neg = s2_signed & bus.in_s2[WIDTH-1];
        // Negating MIN yields MIN, which is the correct unsigned magnitude.
        s1_mag = s1_neg ? (ZERO - bus.in_s1) : bus.in_s1;
        s2_mag = s2_neg ? (ZERO - bus.in_s2) : bus.in_s2;

        // MUL's low half is sign-agnostic, so it always runs unsigned.
        // REM follows the dividend; DIV and MULH* follow the operand XOR.
        acc_neg = 1'b0;
        unique case (bus.in_op)
            OP_MUL:                                acc_neg = 1'b0;
            OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV:  acc_neg = s1_neg ^ s2_neg;
            OP_REM:                                acc_neg = s1_neg;
            default:                               acc_neg = 1'b0;
        endcase

        div_by_zero  = acc_is_div && (bus.in_s2 == ZERO);
        div_overflow = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
                       (bus.in_s1 == MIN_VAL) && (bus.in_s2 == ALL_ONES);
        acc_special  = div_by_zero || div_overflow;

        special_result = ZERO;
        if (div_by_zero) begin
            special_result = bus.in_op[1] ? bus.in_s1 : ALL_ONES;
        end else if (div_overflow) begin
            special_result = bus.in_op[1] ? ZERO : MIN_VAL;
        end
    end

    // -----------------------------------------------------------------------
    // One iteration step
    // -----------------------------------------------------------------------
    // Shift-add multiply: acc:lo holds the running product with the
    // not-yet-consumed multiplier bits in the low end of lo. Each step adds
    // the multiplicand to the high half when the current multiplier bit is
    // set, then shifts the whole WIDTH*2+1 bit quantity right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] mul_lo_next;

    // Restoring divide: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, and shift the resulting
    // quotient bit into lo behind the consumed dividend bits.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc_next;
    logic [WIDTH-1:0] div_lo_next;

    logic [WIDTH-1:0] step_acc_next;
    logic [WIDTH-1:0] step_lo_next;

    always_comb begin
        mul_sum      = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        mul_acc_next = mul_sum[WIDTH:1];
        mul_lo_next  = {mul_sum[0], lo_reg[WIDTH-1:1]};

        div_shift    = {acc_reg, lo_reg[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, opnd_reg});
        // The remainder always stays below the divisor, so the subtraction
        // result fits in WIDTH bits and the carry-out can be ignored.
        div_acc_next = div_ge ? (div_shift[WIDTH-1:0] - opnd_reg) : div_shift[WIDTH-1:0];
        div_lo_next  = {lo_reg[WIDTH-2:0], div_ge};

        step_acc_next = is_div_reg ? div_acc_next : mul_acc_next;
        step_lo_next  = is_div_reg ? div_lo_next  : mul_lo_next;
    end

    // -----------------------------------------------------------------------
    // Final sign correction and result selection, applied to the values
    // produced by the last step so the result is registered on that edge.
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   div_mag;
    logic [WIDTH-1:0]   div_fixed;
    logic [WIDTH-1:0]   final_result;

    always_comb begin
        prod_mag   = {mul_acc_next, mul_lo_next};
        prod_fixed = neg_reg ? ({(2*WIDTH){1'b0}} - prod_mag) : prod_mag;

        div_mag    = sel_alt_reg ? div_acc_next : div_lo_next;
        div_fixed  = neg_reg ? (ZERO - div_mag) : div_mag;

        if (is_div_reg) begin
            final_result = div_fixed;
        end else begin
            final_result = sel_alt_reg ? prod_fixed[2*WIDTH-1:WIDTH] : prod_fixed[WIDTH-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Control and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            is_div_reg     <= 1'b0;
            sel_alt_reg    <= 1'b0;
            neg_reg        <= 1'b0;
            opnd_reg       <= '0;
            acc_reg        <= '0;
            lo_reg         <= '0;
            tag_reg        <= '0;
            out_result_reg <= '0;
            out_tag_reg    <= '0;
        end else if (bus.flush) begin
            // Flush beats both a new issue and a result handshake. The
            // output registers keep their last value; only out_valid drops.
            state_reg <= ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        is_div_reg  <= acc_is_div;
                        sel_alt_reg <= acc_sel_alt;
                        neg_reg     <= acc_neg;
                        tag_reg     <= bus.in_tag;
                        if (acc_special) begin
                            out_result_reg <= special_result;
                            out_tag_reg    <= bus.in_tag;
                            state_reg      <= ST_DONE;
                        end else begin
                            acc_reg   <= ZERO;
                            // Multiply consumes s2 from lo and adds s1;
                            // divide consumes s1 from lo and subtracts s2.
                            opnd_reg  <= acc_is_div ? s2_mag : s1_mag;
                            lo_reg    <= acc_is_div ? s1_mag : s2_mag;
                            cnt_reg   <= CNT_W'(WIDTH);
                            state_reg <= ST_BUSY;
                        end
                    end
                end

                ST_BUSY: begin
                    acc_reg <= step_acc_next;
                    lo_reg  <= step_lo_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        out_result_reg <= final_result;
                        out_tag_reg    <= tag_reg;
                        state_reg      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_int_muldiv_unit
//
// Self-checking bench for int_muldiv_unit at WIDTH=32, TAG_W=6. Expected
// results come from plain 64-bit arithmetic on the RV M-extension rules.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_int_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 6;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int_muldiv_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    int_muldiv_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic        [63:0] p;
        logic signed [63:0] sp;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               ((op == 3'd4 || op == 3'd6) && a == MIN_VAL && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_VAL;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus helper: issue one op, wait (bounded) for the result, hold it
    // for 'hold' cycles, then take it. lat counts rising edges after the
    // accept edge until out_valid is first seen.
    // ---------------------------------------------------------------------
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag, input int hold,
                          output logic [31:0] res, output logic [5:0] tg,
                          output int lat, output bit timed_out);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_s1    = a;
        bus.in_s2    = b;
        bus.in_tag   = tag;
        @(negedge clk);
        bus.in_valid = 1'b0;
        // Scramble operands after accept; the unit must ignore them.
        bus.in_op    = 3'($urandom_range(0, 7));
        bus.in_s1    = $urandom;
        bus.in_s2    = $urandom;
        bus.in_tag   = 6'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        timed_out = (bus.out_valid !== 1'b1);
        res = bus.out_result;
        tg  = bus.out_tag;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("op=%0d s1=%h s2=%h tag=%h -> result=%h tag=%h lat=%0d", op, a, b, tag, res, tg, lat);
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_s1     = 32'd0;
        bus.in_s2     = 32'd0;
        bus.in_tag    = 6'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_result !== 32'd0) begin n_bad++; $display("FAIL reset_out_result: got %h expected 0", bus.out_result); end
        n_cmp++; if (bus.out_tag !== 6'd0) begin n_bad++; $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_latency();
        logic [31:0] res; logic [5:0] tg; int lat; bit to;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 6'h2A, 0, res, tg, lat, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL mul_timeout: got no out_valid expected out_valid"); end
        n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL mul_latency: got %0d expected 32", lat); end
        n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        n_cmp++; if (tg !== 6'h2A) begin n_bad++; $display("FAIL mul_tag: got %h expected 2a", tg); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] s1s [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] s2s [7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
        logic [31:0] exps[7] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1};
        logic [31:0] res; logic [5:0] tg; int lat; bit to;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], s1s[i], s2s[i], 6'(i + 10), 0, res, tg, lat, to);
            n_cmp++; if (res !== exps[i]) begin n_bad++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, exps[i]); end
            n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected 32", i, lat); end
            n_cmp++; if (tg !== 6'(i + 10)) begin n_bad++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, tg, 6'(i + 10)); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
        logic [31:0] s1s [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [31:0] s2s [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        logic [31:0] res; logic [5:0] tg; int lat; bit to;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], s1s[i], s2s[i], 6'(i + 40), 2, res, tg, lat, to);
            n_cmp++; if (res !== exps[i]) begin n_bad++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, exps[i]); end
            // Valid in the first cycle after the accept edge.
            n_cmp++; if (lat != 0) begin n_bad++; $display("FAIL special_latency[%0d]: got %0d expected 0", i, lat); end
            n_cmp++; if (tg !== 6'(i + 40)) begin n_bad++; $display("FAIL special_tag[%0d]: got %h expected %h", i, tg, 6'(i + 40)); end
        end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [5:0] tag;
        logic [31:0] res; logic [5:0] tg; int lat; bit to; int exp_lat;
        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            tag = 6'($urandom);
            exp_lat = is_special(op, a, b) ? 0 : 32;
            run_op(op, a, b, tag, $urandom_range(0, 3), res, tg, lat, to);
            n_cmp++; if (res !== ref_model(op, a, b)) begin n_bad++; $display("FAIL random_result[%0d] op=%0d s1=%h s2=%h: got %h expected %h", i, op, a, b, res, ref_model(op, a, b)); end
            n_cmp++; if (tg !== tag) begin n_bad++; $display("FAIL random_tag[%0d]: got %h expected %h", i, tg, tag); end
            n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a; logic [31:0] b; logic [31:0] exp_a;
        logic [31:0] c; logic [31:0] d; logic [31:0] exp_b;
        int lat;
        a = $urandom & 32'h7FFF_FFFF;
        b = $urandom | 32'd1;
        exp_a = ref_model(3'd4, a, b);
        c = $urandom;
        d = $urandom;
        exp_b = ref_model(3'd0, c, d);
        // Op A: DIV, left waiting under backpressure.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_s1 = a; bus.in_s2 = b; bus.in_tag = 6'h15;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: got out_valid %b expected 1", bus.out_valid); end
        // Offer op B the whole time the result is held back.
        bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_s1 = c; bus.in_s2 = d; bus.in_tag = 6'h2B;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_result !== exp_a) begin n_bad++; $display("FAIL bp_result[%0d]: got %h expected %h", i, bus.out_result, exp_a); end
            n_cmp++; if (bus.out_tag !== 6'h15) begin n_bad++; $display("FAIL bp_tag[%0d]: got %h expected 15", i, bus.out_tag); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        $display("op=4 s1=%h s2=%h tag=15 -> result=%h held 10 cycles", a, b, bus.out_result);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: got in_ready %b expected 0", bus.in_ready); end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
        n_cmp++; if (bus.out_result !== exp_b) begin n_bad++; $display("FAIL b2b_result: got %h expected %h", bus.out_result, exp_b); end
        n_cmp++; if (bus.out_tag !== 6'h2B) begin n_bad++; $display("FAIL b2b_tag: got %h expected 2b", bus.out_tag); end
        $display("op=0 s1=%h s2=%h tag=2b -> result=%h lat=%0d", c, d, bus.out_result, lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [5:0] tg; int lat; bit to; bit seen;
        // Flush sampled at the tenth edge after accept, with a new op offered.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_s1 = 32'd1000; bus.in_s2 = 32'd3; bus.in_tag = 6'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_s1 = 32'd9; bus.in_s2 = 32'd9; bus.in_tag = 6'h3F;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_quiet: got activity expected idle for 40 cycles"); end
        $display("flush during BUSY: op dropped");
        run_op(3'd5, 32'd100, 32'd7, 6'h07, 0, res, tg, lat, to);
        n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL flush_next_result: got %h expected 0000000e", res); end
        n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL flush_next_latency: got %0d expected 32", lat); end

        // Flush together with the output handshake: result dropped, unit idle.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd5; bus.in_s1 = 32'd0; bus.in_s2 = 32'd0; bus.in_tag = 6'h11;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_done_setup: got %b expected 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_done_in_ready: got %b expected 1", bus.in_ready); end
        $display("flush with handshake in DONE: result dropped");
    endtask

    task automatic test_async_reset();
        logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [5:0] tg; int lat; bit to;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_s1 = 32'hFFFF_0000; bus.in_s2 = 32'h1234_5678; bus.in_tag = 6'h33;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_result !== 32'd0) begin n_bad++; $display("FAIL areset_out_result: got %h expected 0", bus.out_result); end
        n_cmp++; if (bus.out_tag !== 6'd0) begin n_bad++; $display("FAIL areset_out_tag: got %h expected 0", bus.out_tag); end
        $display("async reset mid-BUSY: unit cleared");
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom;
        b = $urandom;
        run_op(3'd1, a, b, 6'h0C, 0, res, tg, lat, to);
        n_cmp++; if (res !== ref_model(3'd1, a, b)) begin n_bad++; $display("FAIL areset_recover: got %h expected %h", res, ref_model(3'd1, a, b)); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_directed();
        test_special();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
